// File: rtl/core_pkg.sv
// Shared core constants: opcodes, default widths and register field positions.
package core_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RS_W    = 5;

    localparam logic [OPC_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_S     = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_B     = 7'b1100011;

    // rs1 is read by everything except the upper-immediate and jump forms
    function automatic logic uses_rs1(input logic [OPC_W-1:0] opc);
        return !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    endfunction

    // rs2 is read only by register-register, store and branch forms
    function automatic logic uses_rs2(input logic [OPC_W-1:0] opc);
        return (opc == OP_R || opc == OP_S || opc == OP_B);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: 2 async reads, 1 write, x0 hardwired, write-through bypass.
module regfile_2r1w
    import core_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(NREGS)-1:0]   raddr1,
    input  logic [$clog2(NREGS)-1:0]   raddr2,
    output logic [XLEN-1:0]            rdata1_c,
    output logic [XLEN-1:0]            rdata2_c,
    input  logic                       we,
    input  logic [$clog2(NREGS)-1:0]   waddr,
    input  logic [XLEN-1:0]            wdata
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0] mem [NREGS];

    // Storage update; writes to x0 are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports with same-cycle write bypass
    always_comb begin
        rdata1_c = mem[raddr1];
        rdata2_c = mem[raddr2];
        if (we && (waddr == raddr1)) rdata1_c = wdata;
        if (we && (waddr == raddr2)) rdata2_c = wdata;
        if (raddr1 == AW'(0)) rdata1_c = '0;
        if (raddr2 == AW'(0)) rdata2_c = '0;
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: operand resolve with priority forwarding, load-use stall, ID/EX register.
module decode_issue_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NFWD  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [31:0]                       in_instr,
    input  logic [XLEN-1:0]                   in_pc,
    input  logic [NFWD-1:0]                   fwd_valid,
    input  logic [NFWD*$clog2(NREGS)-1:0]     fwd_addr,
    input  logic [NFWD*XLEN-1:0]              fwd_data,
    input  logic [NFWD-1:0]                   fwd_rdy,
    input  logic                              wb_en,
    input  logic [$clog2(NREGS)-1:0]          wb_addr,
    input  logic [XLEN-1:0]                   wb_data,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [31:0]                       out_instr,
    output logic [XLEN-1:0]                   out_pc,
    output logic [XLEN-1:0]                   out_rs1,
    output logic [XLEN-1:0]                   out_rs2,
    output logic [31:0]                       stall_cycles
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [OPC_W-1:0] opcode;
    logic [AW-1:0]    rs1, rs2;
    logic             rs1_used, rs2_used;
    logic [XLEN-1:0]  rf_rs1, rf_rs2;
    logic [NFWD-1:0]  hit1, hit2;
    logic [XLEN-1:0]  fwd_data_a [NFWD];
    logic [XLEN-1:0]  rs1_val, rs2_val;
    logic             rs1_rdy, rs2_rdy;
    logic             hazard, accept;

    logic             valid_d;
    logic [31:0]      instr_d;
    logic [XLEN-1:0]  pc_d, rs1_d, rs2_d;
    logic [31:0]      stall_d;

    assign opcode   = in_instr[OPC_W-1:0];
    assign rs1      = AW'(in_instr[RS1_LSB +: RS_W]);
    assign rs2      = AW'(in_instr[RS2_LSB +: RS_W]);
    assign rs1_used = uses_rs1(opcode);
    assign rs2_used = uses_rs2(opcode);

    regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .raddr1   (rs1),
        .raddr2   (rs2),
        .rdata1_c (rf_rs1),
        .rdata2_c (rf_rs2),
        .we       (wb_en),
        .waddr    (wb_addr),
        .wdata    (wb_data)
    );

    // Per-source match detection; x0 never matches
    for (genvar k = 0; k < int'(NFWD); k++) begin : g_fwd
        logic [AW-1:0] addr_k;
        assign addr_k        = fwd_addr[k*AW +: AW];
        assign fwd_data_a[k] = fwd_data[k*XLEN +: XLEN];
        assign hit1[k]       = fwd_valid[k] && (addr_k == rs1) && (rs1 != '0);
        assign hit2[k]       = fwd_valid[k] && (addr_k == rs2) && (rs2 != '0);
    end

    // Priority select: scan oldest to youngest so the lowest matching index wins
    always_comb begin
        rs1_val = rf_rs1;
        rs2_val = rf_rs2;
        rs1_rdy = 1'b1;
        rs2_rdy = 1'b1;
        for (int k = int'(NFWD) - 1; k >= 0; k--) begin
            if (hit1[k]) begin
                rs1_val = fwd_data_a[k];
                rs1_rdy = fwd_rdy[k];
            end
            if (hit2[k]) begin
                rs2_val = fwd_data_a[k];
                rs2_rdy = fwd_rdy[k];
            end
        end
    end

    // Not gated by in_valid so in_ready has no combinational path from in_valid
    assign hazard   = (rs1_used && !rs1_rdy) || (rs2_used && !rs2_rdy);
    assign in_ready = flush || (!hazard && (!out_valid || out_ready));
    assign accept   = in_valid && in_ready && !flush;

    // Next-state for the ID/EX register and stall counter
    always_comb begin
        valid_d = out_valid;
        instr_d = out_instr;
        pc_d    = out_pc;
        rs1_d   = out_rs1;
        rs2_d   = out_rs2;
        stall_d = stall_cycles;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            instr_d = in_instr;
            pc_d    = in_pc;
            rs1_d   = rs1_val;
            rs2_d   = rs2_val;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (in_valid && hazard && !flush && (stall_cycles != '1)) begin
            stall_d = stall_cycles + 32'd1;
        end
    end

    // ID/EX register and stall counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_pc       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            stall_cycles <= '0;
        end else begin
            out_valid    <= valid_d;
            out_instr    <= instr_d;
            out_pc       <= pc_d;
            out_rs1      <= rs1_d;
            out_rs2      <= rs2_d;
            stall_cycles <= stall_d;
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage with hand-computed expectations.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [1:0]  fwd_valid;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_rdy;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_rs1;
    logic [31:0] out_rs2;
    logic [31:0] stall_cycles;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    decode_issue_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .fwd_rdy      (fwd_rdy),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [4:0] rd);
        return {f7, s2, s1, 3'b000, rd, 7'b0110011};
    endfunction

    localparam logic [31:0] ADD_3_1_2 = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] SUB_5_4_1 = {7'b0100000, 5'd1, 5'd4, 3'b000, 5'd5, 7'b0110011};
    // lui x6, 0x00020: imm bits put 4 in the rs1 field position
    localparam logic [31:0] LUI_6     = {20'h00020, 5'd6, 7'b0110111};
    // addi x6, x0, 1: imm[4:0] = 1 lands in the rs2 field position
    localparam logic [31:0] ADDI_6    = {12'd1, 5'd0, 3'b000, 5'd6, 7'b0010011};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        fwd_valid = '0;
        fwd_addr  = '0;
        fwd_data  = '0;
        fwd_rdy   = '0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        repeat (2) cyc();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_instr", out_instr, 32'd0);
        chk("reset_stall", stall_cycles, 32'd0);
        reset = 1'b0;

        // Preload x1=5, x2=7
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
        cyc();
        wb_addr = 5'd2; wb_data = 32'd7;
        cyc();
        wb_en = 1'b0;

        // Independent ALU op
        in_valid = 1'b1; in_instr = ADD_3_1_2; in_pc = 32'h100;
        #1;
        chk("add_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_rs1", out_rs1, 32'd5);
        chk("add_rs2", out_rs2, 32'd7);
        chk("add_pc", out_pc, 32'h100);
        chk("add_instr", out_instr, ADD_3_1_2);
        chk("add_stall", stall_cycles, 32'd0);
        cyc();
        chk("bubble_valid", 32'(out_valid), 32'd0);

        // Forwarding priority
        in_valid  = 1'b1; in_instr = ADD_3_1_2;
        fwd_valid = 2'b11; fwd_addr = {5'd1, 5'd1};
        fwd_data  = {32'hBB, 32'hAA}; fwd_rdy = 2'b11;
        cyc();
        chk("prio_young", out_rs1, 32'hAA);
        chk("prio_rs2_rf", out_rs2, 32'd7);
        fwd_valid = 2'b10;
        cyc();
        chk("prio_old", out_rs1, 32'hBB);

        // Load-use stall: x4 produced by a load still in flight
        in_instr  = SUB_5_4_1;
        fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd4};
        fwd_data  = {32'h0, 32'h77}; fwd_rdy = 2'b00;
        #1;
        chk("lu_ready_c0", 32'(in_ready), 32'd0);
        cyc();
        chk("lu_ready_c1", 32'(in_ready), 32'd0);
        chk("lu_bubble", 32'(out_valid), 32'd0);
        cyc();
        chk("lu_stall2", stall_cycles, 32'd2);
        fwd_rdy = 2'b01;
        #1;
        chk("lu_release_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("lu_accept_valid", 32'(out_valid), 32'd1);
        chk("lu_rs1_fwd", out_rs1, 32'h77);
        chk("lu_rs2_rf", out_rs2, 32'd5);
        chk("lu_stall_hold", stall_cycles, 32'd2);

        // No false stall on unused operand fields
        in_instr = LUI_6; fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd4}; fwd_rdy = 2'b00;
        #1;
        chk("lui_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("lui_instr", out_instr, LUI_6);
        in_instr = ADDI_6; in_pc = 32'h180;
        fwd_valid = 2'b11; fwd_addr = {5'd0, 5'd1}; fwd_rdy = 2'b00;
        #1;
        chk("addi_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("addi_instr", out_instr, ADDI_6);
        chk("addi_rs1_x0", out_rs1, 32'd0);
        chk("nofalse_stall", stall_cycles, 32'd2);

        // Back-pressure holds the register, then flush clears it
        fwd_valid = 2'b00; fwd_rdy = 2'b11;
        out_ready = 1'b0; in_instr = ADD_3_1_2; in_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_instr", out_instr, ADDI_6);
            chk("bp_pc", out_pc, 32'h180);
            cyc();
        end
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        cyc();
        chk("flush_discard", 32'(out_valid), 32'd0);

        // Writeback bypass and x0 rule
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = rtype(7'd0, 5'd0, 5'd7, 5'd8);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        cyc();
        chk("wb_bypass", out_rs1, 32'h1234);
        chk("wb_rs2_x0", out_rs2, 32'd0);
        in_instr = rtype(7'd0, 5'd7, 5'd0, 5'd9);
        wb_addr = 5'd0; wb_data = 32'hDEAD;
        cyc();
        chk("x0_bypass", out_rs1, 32'd0);
        chk("x7_commit", out_rs2, 32'h1234);
        wb_en = 1'b0; in_instr = rtype(7'd0, 5'd0, 5'd0, 5'd9);
        cyc();
        chk("x0_readback", out_rs1, 32'd0);
        in_instr = rtype(7'd0, 5'd7, 5'd7, 5'd8);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h5555;
        fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd7}; fwd_data = {32'h0, 32'h6666}; fwd_rdy = 2'b01;
        cyc();
        chk("fwd_over_wb", out_rs1, 32'h6666);
        wb_en = 1'b0; fwd_valid = 2'b00;

        // Asynchronous reset mid-stream
        in_instr = ADD_3_1_2;
        cyc();
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_rs1", out_rs1, 32'd0);
        chk("async_reset_stall", stall_cycles, 32'd0);
        cyc();
        reset = 1'b0;
        in_valid = 1'b1; in_instr = rtype(7'd0, 5'd1, 5'd7, 5'd8);
        cyc();
        in_valid = 1'b0;
        chk("rf_cleared_valid", 32'(out_valid), 32'd1);
        chk("rf_cleared_x7", out_rs1, 32'd0);
        chk("rf_cleared_x1", out_rs2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
